alu_cmd_sequencer: RTL and testbench

Upstream issue stage for `ALU_64`. It buffers operation commands (select code, two 64-bit operands, tag) in a small FIFO and issues them one at a time through the ALU's `bgn`/`stop` handshake. It captures `out` on completion and presents tagged results on a valid/ready port to the downstream consumer. The block exists so that software-style producers never have to track ALU latency or hold operands stable themselves.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_seq_fifo.sv | 71 +++++++
 rtl/alu_cmd_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared types and constants for the ALU command sequencer.
//   state_t    : sequencer FSM states (IDLE, ISSUE, WAIT, DONE)
//   ALU_W      : ALU datapath width (64)
//   SEL_W      : ALU select-code width (5)
//   TAG_MAX_W  : storage width of the command tag field; the top level
//                uses only the low TAG_W bits (TAG_W must not exceed this)
//   alu_cmd_t  : one queued command {sel, op0, op1, tag}
// ---------------------------------------------------------------------------
package alu_seq_pkg;

    localparam int ALU_W     = 64;
    localparam int SEL_W     = 5;
    localparam int TAG_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0]     sel;
        logic [ALU_W-1:0]     op0;
        logic [ALU_W-1:0]     op1;
        logic [TAG_MAX_W-1:0] tag;
    } alu_cmd_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// ---------------------------------------------------------------------------
// alu_seq_fifo
// Synchronous FIFO of alu_cmd_t entries. Head entry is visible on pop_data
// whenever the FIFO is non-empty (show-ahead). Full/empty derive from the
// occupancy count; pointers wrap modulo DEPTH (DEPTH must be a power of 2).
// Parameters:
//   DEPTH     : number of entries (power of two, >= 2)
// Ports:
//   clk       : clock, rising edge
//   rst_b     : asynchronous active-low reset (pointers and count only)
//   push      : write push_data (ignored when full)
//   push_data : entry to write
//   pop       : discard head entry (ignored when empty)
//   pop_data  : current head entry
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module alu_seq_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   push,
    input  alu_cmd_t               push_data,
    input  logic                   pop,
    output alu_cmd_t               pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    alu_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset: stale entries are never observable because
    // the count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
// Issue stage in front of ALU_64. Commands are queued in a small FIFO and
// issued one at a time through the ALU bgn/stop handshake; the ALU result is
// captured and returned with the command tag on a valid/ready port. Operands
// and select stay stable from issue until the result has been accepted.
//
// Build option:
//   ALU_SEQ_TIMEOUT_EN : when defined, a command that sees no alu_stop within
//                        TIMEOUT cycles of ISSUE/WAIT completes with
//                        res_data=0 and res_err=1. Undefined: res_err=0 and
//                        the sequencer waits for alu_stop indefinitely.
// Parameters:
//   DEPTH   : command FIFO entries (power of two, >= 2)
//   TAG_W   : command tag width (<= alu_seq_pkg::TAG_MAX_W)
//   TIMEOUT : ISSUE/WAIT cycle limit (timeout build only)
// Ports:
//   clk, rst_b                       : clock, async active-low reset
//   cmd_valid/cmd_ready              : command handshake (ready = !full)
//   cmd_sel, cmd_op0, cmd_op1, cmd_tag : command payload
//   res_valid/res_ready              : result handshake
//   res_data, res_tag, res_err       : result payload, timeout flag
//   alu_bgn, alu_sel, alu_in_0/1     : to ALU
//   alu_stop, alu_out                : from ALU
//   busy                             : command in flight or queued
//   fifo_count                       : FIFO occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [SEL_W-1:0]       cmd_sel,
    input  logic [ALU_W-1:0]       cmd_op0,
    input  logic [ALU_W-1:0]       cmd_op1,
    input  logic [TAG_W-1:0]       cmd_tag,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ALU_W-1:0]       res_data,
    output logic [TAG_W-1:0]       res_tag,
    output logic                   res_err,
    output logic                   alu_bgn,
    output logic [SEL_W-1:0]       alu_sel,
    output logic [ALU_W-1:0]       alu_in_0,
    output logic [ALU_W-1:0]       alu_in_1,
    input  logic                   alu_stop,
    input  logic [ALU_W-1:0]       alu_out,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    state_t             state;
    alu_cmd_t           push_cmd;
    alu_cmd_t           head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic [TAG_W-1:0]   tag_q;
    logic               unused_head_tag;

    always_comb begin
        push_cmd     = '0;
        push_cmd.sel = cmd_sel;
        push_cmd.op0 = cmd_op0;
        push_cmd.op1 = cmd_op1;
        push_cmd.tag = TAG_MAX_W'(cmd_tag);
    end

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    // Pop is decided purely from registered state, so nothing from the
    // result side or the ALU reaches the FIFO combinationally.
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign res_tag   = tag_q;

    // Upper tag storage bits beyond TAG_W are always zero.
    assign unused_head_tag = ^head.tag;

    alu_seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (fifo_push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT < 1);
    assign res_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            alu_bgn   <= 1'b0;
            alu_sel   <= '0;
            alu_in_0  <= '0;
            alu_in_1  <= '0;
            tag_q     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
            res_err   <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        alu_sel  <= head.sel;
                        alu_in_0 <= head.op0;
                        alu_in_1 <= head.op1;
                        tag_q    <= head.tag[TAG_W-1:0];
                        alu_bgn  <= 1'b1;
                        state    <= ISSUE;
`ifdef ALU_SEQ_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end

                // ISSUE and WAIT differ only in bgn, which is a one-cycle
                // pulse dropped on the first edge after issue. A stop seen
                // already in ISSUE completes the command immediately.
                ISSUE, WAIT: begin
                    alu_bgn <= 1'b0;
                    if (alu_stop) begin
                        res_data  <= alu_out;
                        res_valid <= 1'b1;
`ifdef ALU_SEQ_TIMEOUT_EN
                        res_err   <= 1'b0;
`endif
                        state     <= DONE;
                    end
`ifdef ALU_SEQ_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        res_data  <= '0;
                        res_valid <= 1'b1;
                        res_err   <= 1'b1;
                        state     <= DONE;
                    end
`endif
                    else begin
                        state <= WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end

                // Result held until accepted; stop is ignored here, and
                // operands stay frozen so the ALU sees no new work.
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst_b;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [4:0]        cmd_sel;
    logic [63:0]       cmd_op0;
    logic [63:0]       cmd_op1;
    logic [TAG_W-1:0]  cmd_tag;
    logic              res_valid;
    logic              res_ready;
    logic [63:0]       res_data;
    logic [TAG_W-1:0]  res_tag;
    logic              res_err;
    logic              alu_bgn;
    logic [4:0]        alu_sel;
    logic [63:0]       alu_in_0;
    logic [63:0]       alu_in_1;
    logic              alu_stop;
    logic [63:0]       alu_out;
    logic              busy;
    logic [2:0]        fifo_count;

    typedef struct {
        logic [63:0]      d;
        logic [TAG_W-1:0] t;
        logic             e;
    } res_t;

    res_t res_q[$];     // results observed on the result port
    res_t exp_q[$];     // reference model: commands in arrival order

    int   vectors = 0;
    int   errors  = 0;
    int   bgn_cnt = 0;
    logic stub_on = 1'b1;
    logic [2:0] sr;

    alu_cmd_sequencer #(
        .DEPTH   (4),
        .TAG_W   (TAG_W),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sel    (cmd_sel),
        .cmd_op0    (cmd_op0),
        .cmd_op1    (cmd_op1),
        .cmd_tag    (cmd_tag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .res_err    (res_err),
        .alu_bgn    (alu_bgn),
        .alu_sel    (alu_sel),
        .alu_in_0   (alu_in_0),
        .alu_in_1   (alu_in_1),
        .alu_stop   (alu_stop),
        .alu_out    (alu_out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // ALU stub: stop is a one-cycle pulse three cycles after bgn.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) sr <= 3'b000;
        else        sr <= {sr[1:0], alu_bgn & stub_on};
    end
    assign alu_stop = sr[2];
    assign alu_out  = alu_in_0 + alu_in_1;

    // Result port recorder and bgn pulse counter.
    always @(negedge clk) begin
        if (rst_b && res_valid && res_ready)
            res_q.push_back('{res_data, res_tag, res_err});
        if (alu_bgn) bgn_cnt <= bgn_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [4:0] s, input logic [63:0] a,
                            input logic [63:0] b, input logic [TAG_W-1:0] t);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            vectors++;
            errors++;
            $display("FAIL push_wait cmd_ready=%0b required 1", cmd_ready);
        end else begin
            cmd_valid = 1'b1;
            cmd_sel   = s;
            cmd_op0   = a;
            cmd_op1   = b;
            cmd_tag   = t;
            tick();
            cmd_valid = 1'b0;
            exp_q.push_back('{a + b, t, 1'b0});
        end
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 500 && res_q.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_b     = 1'b0;
        cmd_valid = 1'b0;
        cmd_sel   = '0;
        cmd_op0   = '0;
        cmd_op1   = '0;
        cmd_tag   = '0;
        res_ready = 1'b1;
        #22;
        vectors++;
        if ({cmd_ready, res_valid, res_err, alu_bgn, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl {ready,rvalid,err,bgn,busy}=%b required 10000",
                     {cmd_ready, res_valid, res_err, alu_bgn, busy});
        end
        vectors++;
        if ({res_data, res_tag, alu_sel, alu_in_0, alu_in_1, fifo_count} !== '0) begin
            errors++;
            $display("FAIL reset_data res_data=%0h tag=%0d sel=%0d in0=%0h in1=%0h cnt=%0d required all 0",
                     res_data, res_tag, alu_sel, alu_in_0, alu_in_1, fifo_count);
        end
        @(posedge clk);
        #1 rst_b = 1'b1;
        tick();
    endtask

    task automatic test_single();
        res_t r;
        res_t x;
        int   b0 = bgn_cnt;
        res_ready = 1'b1;
        push_cmd(5'b00011, 64'd15, 64'd5, 4'd2);
        tick();
        vectors++;
        if (alu_bgn !== 1'b1) begin
            errors++;
            $display("FAIL single_bgn_rise alu_bgn=%0b required 1", alu_bgn);
        end
        tick();
        vectors++;
        if (alu_bgn !== 1'b0) begin
            errors++;
            $display("FAIL single_bgn_fall alu_bgn=%0b required 0", alu_bgn);
        end
        tick();
        tick();
        vectors++;
        if ({alu_stop, res_valid} !== 2'b10) begin
            errors++;
            $display("FAIL single_stop {stop,res_valid}=%b required 10", {alu_stop, res_valid});
        end
        tick();
        vectors++;
        if ({res_valid, res_data, res_tag, res_err} !== {1'b1, 64'd20, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL single_result valid=%0b data=%0d tag=%0d err=%0b required 1 20 2 0",
                     res_valid, res_data, res_tag, res_err);
        end
        repeat (4) tick();
        vectors++;
        if (bgn_cnt - b0 !== 1) begin
            errors++;
            $display("FAIL single_bgn_count pulses=%0d required 1", bgn_cnt - b0);
        end
        wait_results(1);
        x = exp_q.pop_front();
        vectors++;
        if (res_q.size() != 1) begin
            errors++;
            $display("FAIL single_count results=%0d required 1", res_q.size());
        end else begin
            r = res_q.pop_front();
            if (r.d !== x.d || r.t !== x.t || r.e !== 1'b0) begin
                errors++;
                $display("FAIL single_port data=%0d tag=%0d err=%0b required %0d %0d 0",
                         r.d, r.t, r.e, x.d, x.t);
            end
        end
        res_q.delete();
    endtask

    task automatic test_fill_drain();
        res_t r;
        res_t x;
        res_ready = 1'b0;
        push_cmd(5'b00011, 64'd100, 64'd0, 4'd9);
        for (int i = 0; i < 50 && !res_valid; i++) tick();
        for (int k = 1; k <= 4; k++)
            push_cmd(5'b00011, 64'(k), 64'd10, 4'(k));
        vectors++;
        if ({cmd_ready, fifo_count, busy} !== {1'b0, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL fill_full ready=%0b count=%0d busy=%0b required 0 4 1",
                     cmd_ready, fifo_count, busy);
        end
        res_ready = 1'b1;
        wait_results(exp_q.size());
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            vectors++;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL fill_missing no result, required data=%0d tag=%0d", x.d, x.t);
            end else begin
                r = res_q.pop_front();
                if (r.d !== x.d || r.t !== x.t || r.e !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_order data=%0d tag=%0d err=%0b required %0d %0d 0",
                             r.d, r.t, r.e, x.d, x.t);
                end
            end
        end
        res_q.delete();
    endtask

    task automatic test_backpressure();
        res_t        r;
        res_t        x;
        logic [63:0] d;
        logic [63:0] s;
        int          b;
        res_ready = 1'b0;
        push_cmd(5'b00001, 64'hDEAD_0000, 64'h0000_BEEF, 4'd5);
        push_cmd(5'b00010, 64'd40, 64'd2, 4'd6);
        for (int i = 0; i < 50 && !res_valid; i++) tick();
        tick();
        d = res_data;
        s = alu_in_0;
        b = bgn_cnt;
        vectors++;
        if (fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL bp_count count=%0d required 1", fifo_count);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (res_valid !== 1'b1 || res_data !== d || fifo_count !== 3'd1 ||
                bgn_cnt !== b || alu_in_0 !== s) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d valid=%0b data=%0h cnt=%0d bgn=%0d required 1 %0h 1 %0d",
                         i, res_valid, res_data, fifo_count, bgn_cnt, d, b);
            end
        end
        res_ready = 1'b1;
        wait_results(exp_q.size());
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            vectors++;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL bp_missing no result, required data=%0h tag=%0d", x.d, x.t);
            end else begin
                r = res_q.pop_front();
                if (r.d !== x.d || r.t !== x.t || r.e !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_result data=%0h tag=%0d err=%0b required %0h %0d 0",
                             r.d, r.t, r.e, x.d, x.t);
                end
            end
        end
        res_q.delete();
    endtask

    task automatic test_simul_push_pop();
        res_t r;
        res_t x;
        res_ready = 1'b0;
        push_cmd(5'b00011, 64'd1000, 64'd7, 4'd7);
        for (int i = 0; i < 50 && !res_valid; i++) tick();
        push_cmd(5'b00011, 64'd2000, 64'd8, 4'd8);
        push_cmd(5'b00011, 64'd3000, 64'd9, 4'd9);
        res_ready = 1'b1;
        tick();
        vectors++;
        if (fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL pp_before count=%0d required 2", fifo_count);
        end
        cmd_valid = 1'b1;
        cmd_sel   = 5'b00011;
        cmd_op0   = 64'd4000;
        cmd_op1   = 64'd10;
        cmd_tag   = 4'd10;
        exp_q.push_back('{64'd4010, 4'd10, 1'b0});
        tick();
        cmd_valid = 1'b0;
        vectors++;
        if ({fifo_count, alu_bgn} !== {3'd2, 1'b1}) begin
            errors++;
            $display("FAIL pp_overlap count=%0d bgn=%0b required 2 1", fifo_count, alu_bgn);
        end
        wait_results(exp_q.size());
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            vectors++;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL pp_missing no result, required data=%0d tag=%0d", x.d, x.t);
            end else begin
                r = res_q.pop_front();
                if (r.d !== x.d || r.t !== x.t || r.e !== 1'b0) begin
                    errors++;
                    $display("FAIL pp_order data=%0d tag=%0d err=%0b required %0d %0d 0",
                             r.d, r.t, r.e, x.d, x.t);
                end
            end
        end
        res_q.delete();
    endtask

    task automatic test_random();
        res_t r;
        res_t x;
        int   n = 24;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    push_cmd(5'($urandom_range(0, 31)), {$urandom, $urandom},
                             {$urandom, $urandom}, TAG_W'($urandom));
                    repeat ($urandom_range(0, 3)) tick();
                end
            end
            begin
                for (int j = 0; j < 3000 && res_q.size() < n; j++) begin
                    res_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                res_ready = 1'b1;
            end
        join
        wait_results(exp_q.size());
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            vectors++;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL rand_missing no result, required data=%0h tag=%0d", x.d, x.t);
            end else begin
                r = res_q.pop_front();
                if (r.d !== x.d || r.t !== x.t || r.e !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_result data=%0h tag=%0d err=%0b required %0h %0d 0",
                             r.d, r.t, r.e, x.d, x.t);
                end
            end
        end
        vectors++;
        if (res_q.size() != 0) begin
            errors++;
            $display("FAIL rand_extra results=%0d required 0", res_q.size());
        end
        res_q.delete();
    endtask

`ifdef ALU_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        res_t r;
        res_t x;
        res_ready = 1'b1;
        stub_on   = 1'b0;
        push_cmd(5'b00011, 64'd7, 64'd9, 4'd11);
        x = exp_q.pop_front();
        exp_q.push_back('{64'd0, x.t, 1'b1});
        wait_results(1);
        stub_on = 1'b1;
        push_cmd(5'b00011, 64'd7, 64'd9, 4'd12);
        wait_results(2);
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            vectors++;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL tmo_missing no result, required data=%0d tag=%0d err=%0b", x.d, x.t, x.e);
            end else begin
                r = res_q.pop_front();
                if (r.d !== x.d || r.t !== x.t || r.e !== x.e) begin
                    errors++;
                    $display("FAIL tmo_result data=%0d tag=%0d err=%0b required %0d %0d %0b",
                             r.d, r.t, r.e, x.d, x.t, x.e);
                end
            end
        end
        res_q.delete();
    endtask
`endif

    task automatic test_reset_mid();
        int b;
        res_ready = 1'b1;
        stub_on   = 1'b0;
        for (int k = 1; k <= 4; k++)
            push_cmd(5'b00011, 64'(k), 64'd1, 4'(k));
        vectors++;
        if ({fifo_count, alu_bgn, busy} !== {3'd3, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rmid_pre count=%0d bgn=%0b busy=%0b required 3 0 1",
                     fifo_count, alu_bgn, busy);
        end
        #2 rst_b = 1'b0;
        #1;
        vectors++;
        if ({cmd_ready, res_valid, res_err, alu_bgn, busy, fifo_count} !== {5'b10000, 3'd0}) begin
            errors++;
            $display("FAIL rmid_reset ready=%0b rvalid=%0b err=%0b bgn=%0b busy=%0b cnt=%0d required 1 0 0 0 0 0",
                     cmd_ready, res_valid, res_err, alu_bgn, busy, fifo_count);
        end
        vectors++;
        if ({res_data, res_tag, alu_sel, alu_in_0, alu_in_1} !== '0) begin
            errors++;
            $display("FAIL rmid_data data=%0h tag=%0d sel=%0d in0=%0h required 0",
                     res_data, res_tag, alu_sel, alu_in_0);
        end
        exp_q.delete();
        stub_on = 1'b1;
        tick();
        tick();
        rst_b = 1'b1;
        b = bgn_cnt;
        repeat (30) tick();
        vectors++;
        if (res_q.size() != 0 || bgn_cnt !== b || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_after results=%0d new_bgn=%0d busy=%0b required 0 0 0",
                     res_q.size(), bgn_cnt - b, busy);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_backpressure();
        test_simul_push_pop();
        test_random();
`ifdef ALU_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
